// File: rtl/ctr_run_pkg.sv
// ctr_run_pkg: shared state encoding and io pin map for the run controller
package ctr_run_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int PIN_START  = 0;
    localparam int PIN_ABORT  = 1;
    localparam int PIN_MODE   = 2;
    localparam int PIN_TICK   = 3;
    localparam int PIN_TC_LSB = 4;

    localparam int BIT_BUSY = 12;
    localparam int BIT_DONE = 13;
    localparam int BIT_WRAP = 14;
    localparam int BIT_IGN  = 15;

    localparam int CNT_BITS = 12;

endpackage

// File: rtl/ctr_run_ctrl_core.sv
// ctr_core: W-bit counter with clear/load/enable and a look-ahead terminal compare
module ctr_core #(
    parameter int W = 12
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr_i,
    input  logic         en_i,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic [W-1:0] tc_i,
    output logic [W-1:0] count_o,
    output logic         eq_next_o
);

    logic [W-1:0] count_q, count_d, count_inc;

    always_comb begin
        count_inc = count_q + W'(1);
        count_d   = clr_i ? '0 : load_i ? load_val_i : en_i ? count_inc : count_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) count_q <= '0;
        else        count_q <= count_d;
    end

    assign count_o   = count_q;
    assign eq_next_o = (count_inc == tc_i);

endmodule

// File: rtl/ctr_run_ctrl.sv
// ctr_run_ctrl: sequences the user counter from synchronized io pins (one-shot or auto-reload)
// and reports count, busy, done, wrapped and start_ignored on io_out.
module ctr_run_ctrl
    import ctr_run_pkg::*;
#(
    parameter int W           = 12,
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] io_in,
    output logic [15:0] io_out,
    output logic [15:0] io_oeb
);

    if (W > CNT_BITS || W < 1 || SYNC_STAGES < 2) begin : g_bad_param
        $error("ctr_run_ctrl: W must be 1..12 and SYNC_STAGES >= 2");
    end

    logic [SYNC_STAGES-1:0][3:0] sync_q;
    logic [3:0]   sync_s;
    logic         start_d_q;
    logic         start_s, abort_s, mode_s, tick_s, start_evt;
    logic [W-1:0] tc_in, tc_q, tc_d, count;
    logic         eq_next;
    logic         wrap_q, wrap_d, ign_q, ign_d;
    logic         busy, done, launch, term_tick, clr, load, en;
    state_e       state_q, state_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q    <= '0;
            start_d_q <= 1'b0;
        end else begin
            sync_q    <= {sync_q[SYNC_STAGES-2:0], io_in[3:0]};
            start_d_q <= start_s;
        end
    end

    always_comb begin
        sync_s    = sync_q[SYNC_STAGES-1];
        start_s   = sync_s[PIN_START];
        abort_s   = sync_s[PIN_ABORT];
        mode_s    = sync_s[PIN_MODE];
        tick_s    = sync_s[PIN_TICK];
        start_evt = start_s & ~start_d_q;
        tc_in     = io_in[PIN_TC_LSB +: W];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // abort beats start, start beats tick; a zero terminal count finishes immediately
    always_comb begin
        state_d = abort_s ? IDLE :
                  launch ? ((tc_in == '0) ? DONE : RUN) :
                  (term_tick && !mode_s) ? DONE : state_q;
    end

    always_comb begin
        busy      = (state_q == RUN);
        done      = (state_q == DONE);
        launch    = start_evt && !busy;
        term_tick = busy && tick_s && eq_next;
        clr       = abort_s || launch || (term_tick && mode_s);
        load      = term_tick && !mode_s;
        en        = busy && tick_s;
    end

    always_comb begin
        tc_d   = (!abort_s && launch) ? tc_in : tc_q;
        wrap_d = (abort_s || launch) ? 1'b0 : (term_tick && mode_s) ? 1'b1 : wrap_q;
        ign_d  = abort_s ? 1'b0 : (busy && start_evt) ? 1'b1 : ign_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tc_q   <= '0;
            wrap_q <= 1'b0;
            ign_q  <= 1'b0;
        end else begin
            tc_q   <= tc_d;
            wrap_q <= wrap_d;
            ign_q  <= ign_d;
        end
    end

    ctr_core #(.W(W)) u_core (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr_i     (clr),
        .en_i      (en),
        .load_i    (load),
        .load_val_i(tc_q),
        .tc_i      (tc_q),
        .count_o   (count),
        .eq_next_o (eq_next)
    );

    always_comb begin
        io_out           = '0;
        io_out[CNT_BITS-1:0] = CNT_BITS'(count);
        io_out[BIT_BUSY] = busy;
        io_out[BIT_DONE] = done;
        io_out[BIT_WRAP] = wrap_q;
        io_out[BIT_IGN]  = ign_q;
        io_oeb           = 16'hFFFF;
    end

endmodule

// File: tb/tb_ctr_run_ctrl.sv
// tb_ctr_run_ctrl: directed scenarios plus random bursts, checked against a behavioural
// model that applies the run rules to pin samples delayed by the synchronizer depth.
module tb_ctr_run_ctrl;

    localparam int SS = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] io_in = '0;
    logic [15:0] io_out, io_oeb;

    int n_chk = 0;
    int n_fail = 0;

    bit         m_busy, m_done, m_wrap, m_ign, m_eff_tick;
    int         m_cnt, m_tc;
    logic [3:0] hist[$];

    ctr_run_ctrl #(.W(12), .SYNC_STAGES(SS)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .io_in (io_in),
        .io_out(io_out),
        .io_oeb(io_oeb)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] pins(bit st, bit ab, bit md, bit tk, int tc);
        return {12'(tc), tk, md, ab, st};
    endfunction

    function automatic logic [15:0] m_out();
        return {m_ign, m_wrap, m_done, m_busy, 12'(m_cnt)};
    endfunction

    task automatic m_reset();
        m_busy = 0; m_done = 0; m_wrap = 0; m_ign = 0; m_eff_tick = 0;
        m_cnt = 0; m_tc = 0;
        hist = {4'h0, 4'h0, 4'h0};
    endtask

    // pins seen by the controller at an edge are those sampled SS edges earlier
    task automatic m_step(logic [15:0] v);
        logic [3:0] e;
        bit pst, st_evt;
        hist.push_back(v[3:0]);
        e   = hist[hist.size()-1-SS];
        pst = hist[hist.size()-2-SS][0];
        while (hist.size() > 8) void'(hist.pop_front());
        st_evt = e[0] && !pst;
        m_eff_tick = e[3];
        if (e[1]) begin
            m_busy = 0; m_done = 0; m_cnt = 0; m_wrap = 0; m_ign = 0;
        end else if (st_evt && !m_busy) begin
            m_tc = int'(v[15:4]); m_cnt = 0; m_wrap = 0;
            m_busy = (m_tc != 0); m_done = (m_tc == 0);
        end else if (m_busy) begin
            if (st_evt) m_ign = 1;
            if (e[3]) begin
                if (m_cnt + 1 == m_tc) begin
                    if (e[2]) begin m_cnt = 0; m_wrap = 1; end
                    else begin m_cnt = m_tc; m_busy = 0; m_done = 1; end
                end else m_cnt++;
            end
        end
    endtask

    task automatic cycle(logic [15:0] v);
        io_in = v;
        @(posedge clk);
        if (rst_n) m_step(v);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 0;
        m_reset();
        repeat (3) cycle('0);
        n_chk++; if (io_out !== 16'h0) begin n_fail++; $display("FAIL reset_out: got %h expected %h", io_out, 16'h0); end
        n_chk++; if (io_oeb !== 16'hFFFF) begin n_fail++; $display("FAIL reset_oeb: got %h expected %h", io_oeb, 16'hFFFF); end
        rst_n = 1;
        repeat (3) cycle('0);
        n_chk++; if (io_out !== 16'h0) begin n_fail++; $display("FAIL idle_after_reset: got %h expected %h", io_out, 16'h0); end
    endtask

    task automatic test_oneshot();
        int rise = -1;
        for (int i = 1; i <= 20; i++) begin
            cycle(pins(1, 0, 0, 1, 5));
            n_chk++; if (io_out !== m_out()) begin n_fail++; $display("FAIL oneshot_model c%0d: got %h expected %h", i, io_out, m_out()); end
            if (rise < 0 && io_out[12]) rise = i;
        end
        n_chk++; if (rise != SS + 1) begin n_fail++; $display("FAIL oneshot_busy_latency: got %0d expected %0d", rise, SS + 1); end
        n_chk++; if (io_out[15:0] !== 16'h2005) begin n_fail++; $display("FAIL oneshot_final: got %h expected %h", io_out, 16'h2005); end
        repeat (3) cycle(pins(0, 0, 0, 1, 5));
        n_chk++; if (io_out !== 16'h2005) begin n_fail++; $display("FAIL oneshot_hold: got %h expected %h", io_out, 16'h2005); end
        repeat (3) cycle('0);
    endtask

    task automatic test_wrap();
        for (int i = 1; i <= 20; i++) begin
            cycle(pins(1, 0, 1, 1, 3));
            n_chk++; if (io_out !== m_out()) begin n_fail++; $display("FAIL wrap_model c%0d: got %h expected %h", i, io_out, m_out()); end
            if (i >= SS + 2) begin
                n_chk++; if (io_out[11:0] !== 12'((i - SS - 1) % 3)) begin n_fail++; $display("FAIL wrap_seq c%0d: got %0d expected %0d", i, io_out[11:0], (i - SS - 1) % 3); end
            end
        end
        n_chk++; if (io_out[14:12] !== 3'b101) begin n_fail++; $display("FAIL wrap_flags: got %b expected %b", io_out[14:12], 3'b101); end
        repeat (3) cycle(pins(0, 1, 0, 0, 0));
        repeat (3) cycle('0);
        n_chk++; if (io_out !== 16'h0) begin n_fail++; $display("FAIL wrap_abort: got %h expected %h", io_out, 16'h0); end
    endtask

    task automatic test_zero();
        bit saw_busy = 0;
        for (int i = 1; i <= 6; i++) begin
            cycle(pins(1, 0, 0, 1, 0));
            n_chk++; if (io_out !== m_out()) begin n_fail++; $display("FAIL zero_model c%0d: got %h expected %h", i, io_out, m_out()); end
            saw_busy |= io_out[12];
        end
        n_chk++; if (saw_busy) begin n_fail++; $display("FAIL zero_busy: got 1 expected 0"); end
        n_chk++; if (io_out !== 16'h2000) begin n_fail++; $display("FAIL zero_done: got %h expected %h", io_out, 16'h2000); end
        repeat (3) cycle('0);
    endtask

    task automatic test_abort_ignore();
        repeat (3) cycle(pins(1, 0, 0, 0, 20));
        repeat (7) cycle(pins(1, 0, 0, 1, 20));
        repeat (3) cycle(pins(1, 0, 0, 0, 20));
        n_chk++; if (io_out !== 16'h1007) begin n_fail++; $display("FAIL abort_pre_count: got %h expected %h", io_out, 16'h1007); end
        repeat (3) cycle(pins(0, 0, 0, 0, 20));
        repeat (3) cycle(pins(1, 0, 0, 0, 20));
        n_chk++; if (io_out !== 16'h9007) begin n_fail++; $display("FAIL start_ignored: got %h expected %h", io_out, 16'h9007); end
        n_chk++; if (io_out !== m_out()) begin n_fail++; $display("FAIL ignore_model: got %h expected %h", io_out, m_out()); end
        repeat (3) cycle(pins(0, 0, 0, 0, 20));
        repeat (3) cycle(pins(1, 1, 0, 1, 20));
        n_chk++; if (io_out !== 16'h0) begin n_fail++; $display("FAIL abort_wins: got %h expected %h", io_out, 16'h0); end
        repeat (3) cycle(pins(1, 0, 0, 0, 20));
        n_chk++; if (io_out !== 16'h0) begin n_fail++; $display("FAIL abort_stays_idle: got %h expected %h", io_out, 16'h0); end
        repeat (3) cycle('0);
    endtask

    task automatic test_restart_async();
        int drop = -1;
        bit hit = 0;
        for (int i = 1; i <= 30 && !hit; i++) begin
            cycle(pins(1, 0, 0, 1, 5));
            hit = io_out[13];
        end
        n_chk++; if (io_out !== 16'h2005) begin n_fail++; $display("FAIL restart_first_run: got %h expected %h", io_out, 16'h2005); end
        repeat (3) cycle(pins(0, 0, 0, 1, 5));
        hit = 0;
        for (int i = 1; i <= 30 && !hit; i++) begin
            cycle(pins(1, 0, 0, 1, 2));
            n_chk++; if (io_out !== m_out()) begin n_fail++; $display("FAIL restart_model c%0d: got %h expected %h", i, io_out, m_out()); end
            if (drop < 0 && !io_out[13]) drop = i;
            hit = (drop > 0) && io_out[13];
        end
        n_chk++; if (drop != SS + 1) begin n_fail++; $display("FAIL restart_done_drop: got %0d expected %0d", drop, SS + 1); end
        n_chk++; if (io_out !== 16'h2002) begin n_fail++; $display("FAIL restart_final: got %h expected %h", io_out, 16'h2002); end
        repeat (3) cycle('0);
        repeat (8) cycle(pins(1, 0, 0, 1, 100));
        n_chk++; if (io_out !== 16'h1005) begin n_fail++; $display("FAIL async_pre: got %h expected %h", io_out, 16'h1005); end
        #3 rst_n = 0;
        #1;
        n_chk++; if (io_out !== 16'h0) begin n_fail++; $display("FAIL async_reset: got %h expected %h", io_out, 16'h0); end
        m_reset();
        #2 rst_n = 1;
        repeat (3) cycle('0);
        n_chk++; if (io_out !== 16'h0) begin n_fail++; $display("FAIL async_after: got %h expected %h", io_out, 16'h0); end
    endtask

    task automatic test_toggle();
        int n_hi = 0;
        int hi_at_done = -1;
        logic [11:0] prev_cnt;
        bit prev_busy;
        repeat (3) cycle(pins(1, 0, 0, 0, 4));
        for (int i = 0; i < 20; i++) begin
            prev_cnt  = io_out[11:0];
            prev_busy = io_out[12];
            cycle(pins(1, 0, 0, (i % 2) == 0, 4));
            n_chk++; if (io_out !== m_out()) begin n_fail++; $display("FAIL toggle_model c%0d: got %h expected %h", i, io_out, m_out()); end
            if (!m_eff_tick) begin
                n_chk++; if (io_out[11:0] !== prev_cnt) begin n_fail++; $display("FAIL toggle_low_tick c%0d: got %0d expected %0d", i, io_out[11:0], prev_cnt); end
            end
            if (m_eff_tick && prev_busy) n_hi++;
            if (hi_at_done < 0 && io_out[13]) hi_at_done = n_hi;
        end
        n_chk++; if (hi_at_done != 4) begin n_fail++; $display("FAIL toggle_ticks_to_done: got %0d expected %0d", hi_at_done, 4); end
        n_chk++; if (io_out !== 16'h2004) begin n_fail++; $display("FAIL toggle_final: got %h expected %h", io_out, 16'h2004); end
        repeat (3) cycle('0);
    endtask

    task automatic test_random();
        int tc;
        bit md, st, ab, tk;
        for (int b = 0; b < 12; b++) begin
            tc = $urandom_range(0, 9);
            md = 1'($urandom_range(0, 1));
            repeat (3) cycle(pins(0, 0, md, 0, tc));
            for (int i = 0; i < 40; i++) begin
                st = ($urandom_range(0, 3) != 0);
                ab = ($urandom_range(0, 24) == 0);
                tk = 1'($urandom_range(0, 1));
                if ($urandom_range(0, 9) == 0) md = !md;
                cycle(pins(st, ab, md, tk, tc));
                n_chk++; if (io_out !== m_out()) begin n_fail++; $display("FAIL random_model b%0d c%0d: got %h expected %h", b, i, io_out, m_out()); end
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_oneshot();
        test_wrap();
        test_zero();
        test_abort_ignore();
        test_restart_async();
        test_toggle();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
